udma_crc_chk: RTL and testbench
===============================

Name: udma_crc_chk

Overview:
Receive-side CRC checker for ATA Ultra-DMA bursts on the HDD adaptor data path. It accumulates the CRC-16 (G(X)=X16+X12+X5+1) over every 16-bit word accepted during a burst. At burst termination it compares the result with the CRC word sent by the far end and reports pass or fail. It sits beside the UDMA receive FIFO write port and feeds the status/error register block.

Parameters:
SEED, 16'h4ABA, CRC register value loaded at burst start (ATA UDMA seed)
WCNT_W, 16, width of the burst word counter

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST_n  in  1  asynchronous active-low reset
burst_start  in  1  one-cycle pulse; begin a new burst
data_valid  in  1  data word qualifier
data  in  16  received UDMA data word
burst_end  in  1  one-cycle pulse; burst terminated, crc_rx valid this cycle
crc_rx  in  16  CRC word received from the far end
err_clr  in  1  clears err_sticky
busy  out  1  high in ACTIVE or CHECK
crc_value  out  16  running CRC register
word_cnt  out  WCNT_W  words accepted in current/last burst, saturating
done  out  1  one-cycle pulse, check complete
crc_ok  out  1  valid with done; 1 = match
err_sticky  out  1  set on any mismatch, held until err_clr

Behaviour:
- Reset (async, RST_n=0): state IDLE, crc_value=SEED, word_cnt=0, done=0, crc_ok=0, err_sticky=0, busy=0; captured crc_rx=0.
- CRC step per accepted word, defined serially. For i=0..15 in order: fb = data[i] ^ crc[15]; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0). Data LSB first. The RTL implements the fully unrolled single-cycle equivalent.
- States: IDLE, ACTIVE, CHECK.
- IDLE: burst_start -> ACTIVE, crc_value<=SEED, word_cnt<=0. data_valid and burst_end are ignored.
- ACTIVE: data_valid=1 -> crc_value<=step(crc_value,data), word_cnt+1, saturating at all-ones. Update is visible the next cycle.
- ACTIVE, burst_end=1: crc_rx captured -> CHECK. If data_valid is high in the same cycle, that word is included first.
- ACTIVE, burst_start=1: restart. Reload SEED, clear word_cnt, stay ACTIVE, no done. burst_start has priority over data_valid and burst_end in the same cycle.
- CHECK (exactly one cycle): compare crc_value with the captured crc_rx, then -> IDLE. At that edge done<=1 and crc_ok<=(equal). On mismatch, err_sticky<=1. All inputs are ignored in CHECK.
- Latency: burst_end at edge N, done high for the cycle after edge N+1. crc_ok holds until the next done. crc_value and word_cnt hold after the burst until the next burst_start.
- err_clr clears err_sticky. A set in the same cycle wins over the clear.
- Zero-word burst: crc_value=SEED is compared normally.
- Reset mid-burst: immediate return to the reset values. No done.

Optional Feature:
UDMA_CRC_CHK_SYNDROME_EN
- Defined: adds output syndrome[15:0], registered with done, equal to crc_value ^ captured crc_rx; it is 0 on pass. Reset value 0.
- Undefined: port and register are absent. All other behaviour is identical.

Decomposition:
- Shared package udma_crc_pkg:
  - CRC16_POLY=16'h1021 and UDMA_CRC_SEED=16'h4ABA.
  - State enum {IDLE, ACTIVE, CHECK}.
  - Pure function crc16_next(crc, data) implementing the unrolled step.
- One natural sub-module: crc16_word_step, a combinational wrapper of crc16_next. The transmit-side generator can reuse it.
- FSM, counter and compare stay in udma_crc_chk.

Test Plan:
1. SEED=16'h0000; start, data 16'h8000, end with crc_rx=16'h1021 -> crc_value=16'h1021, done pulse 2 cycles after burst_end, crc_ok=1, word_cnt=1.
2. SEED=16'h0000; start, data 16'h4000, end with crc_rx=16'h1021 -> crc_value=16'h2042, crc_ok=0, err_sticky=1; syndrome=16'h3063 when the macro is defined. Then pulse err_clr -> err_sticky=0.
3. Default SEED; start then immediate end, crc_rx=16'h4ABA -> zero-word burst, crc_ok=1, word_cnt=0.
4. SEED=0; start, data 16'h8000 with data_valid and burst_end in the same cycle, crc_rx=16'h1021 -> word included, crc_ok=1.
5. Start, 3 words, burst_start again, then data 16'h8000 (SEED=0), end with crc_rx=16'h1021 -> restart honored, word_cnt=1, crc_ok=1. data_valid pulses in IDLE leave crc_value unchanged.
6. RST_n low mid-burst after 2 words -> all outputs at reset values asynchronously, no done. Then a normal burst passes.

Source files
------------

// File: rtl/udma_crc_pkg.sv
// udma_crc_pkg: shared CRC-16 (x^16+x^12+x^5+1) constants, checker state type and word step function.
package udma_crc_pkg;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] UDMA_CRC_SEED = 16'h4ABA;

    typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} crc_state_e;

    // Word data enters LSB first; the loop unrolls into a single XOR network.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 16; i++) begin
            fb = data[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        return c;
    endfunction
endpackage

// File: rtl/crc16_word_step.sv
// crc16_word_step: combinational one-word CRC-16 update, shared by the UDMA receive checker and transmit generator.
module crc16_word_step
    import udma_crc_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);
    assign crc_o = crc16_next(crc_i, data_i);
endmodule

// File: rtl/udma_crc_chk.sv
// udma_crc_chk: UDMA receive-burst CRC-16 checker with pass/fail pulse and sticky error.
// Define UDMA_CRC_CHK_SYNDROME_EN to add the registered syndrome output.
module udma_crc_chk
    import udma_crc_pkg::*;
#(
    parameter logic [15:0] SEED   = UDMA_CRC_SEED,
    parameter int          WCNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              burst_start,
    input  logic              data_valid,
    input  logic [15:0]       data,
    input  logic              burst_end,
    input  logic [15:0]       crc_rx,
    input  logic              err_clr,
    output logic              busy,
    output logic [15:0]       crc_value,
    output logic [WCNT_W-1:0] word_cnt,
    output logic              done,
    output logic              crc_ok,
    output logic              err_sticky
`ifdef UDMA_CRC_CHK_SYNDROME_EN
   ,output logic [15:0]       syndrome
`endif
);
    crc_state_e        state_q;
    logic [15:0]       crc_q, crc_d, crc_rx_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              done_q, ok_q, err_q;
`ifdef UDMA_CRC_CHK_SYNDROME_EN
    logic [15:0]       syn_q;
    assign syndrome = syn_q;
`endif

    crc16_word_step u_step (
        .crc_i  (crc_q),
        .data_i (data),
        .crc_o  (crc_d)
    );

    // Later assignments win, so a mismatch in CHECK overrides a same-cycle err_clr.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            crc_q    <= SEED;
            crc_rx_q <= '0;
            wcnt_q   <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef UDMA_CRC_CHK_SYNDROME_EN
            syn_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (err_clr) err_q <= 1'b0;
            case (state_q)
                IDLE: if (burst_start) begin
                    state_q <= ACTIVE;
                    crc_q   <= SEED;
                    wcnt_q  <= '0;
                end
                ACTIVE: if (burst_start) begin
                    crc_q  <= SEED;
                    wcnt_q <= '0;
                end else begin
                    if (data_valid) begin
                        crc_q <= crc_d;
                        if (!(&wcnt_q)) wcnt_q <= wcnt_q + 1'b1;
                    end
                    if (burst_end) begin
                        crc_rx_q <= crc_rx;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    ok_q    <= (crc_q == crc_rx_q);
                    if (crc_q != crc_rx_q) err_q <= 1'b1;
`ifdef UDMA_CRC_CHK_SYNDROME_EN
                    syn_q   <= crc_q ^ crc_rx_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign crc_value  = crc_q;
    assign word_cnt   = wcnt_q;
    assign done       = done_q;
    assign crc_ok     = ok_q;
    assign err_sticky = err_q;
endmodule

// File: tb/tb_udma_crc_chk.sv
// tb_udma_crc_chk: directed bench for udma_crc_chk with a behavioural model checked every cycle.
// Two instances share stimulus: seed 0 with a 4-bit counter, and the default seed with 16 bits.
module tb_udma_crc_chk;
    logic        CLK = 1'b0;
    logic        RST_n;
    logic        burst_start, data_valid, burst_end, err_clr;
    logic [15:0] data, crc_rx;

    logic        busy[2], done[2], crc_ok[2], err_sticky[2];
    logic [15:0] crc_value[2];
    logic [3:0]  wc0;
    logic [15:0] wc1;
`ifdef UDMA_CRC_CHK_SYNDROME_EN
    logic [15:0] syndrome[2];
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    udma_crc_chk #(.SEED(16'h0000), .WCNT_W(4)) u0 (
        .CLK(CLK), .RST_n(RST_n), .burst_start(burst_start), .data_valid(data_valid),
        .data(data), .burst_end(burst_end), .crc_rx(crc_rx), .err_clr(err_clr),
        .busy(busy[0]), .crc_value(crc_value[0]), .word_cnt(wc0), .done(done[0]),
        .crc_ok(crc_ok[0]), .err_sticky(err_sticky[0])
`ifdef UDMA_CRC_CHK_SYNDROME_EN
       ,.syndrome(syndrome[0])
`endif
    );

    udma_crc_chk u1 (
        .CLK(CLK), .RST_n(RST_n), .burst_start(burst_start), .data_valid(data_valid),
        .data(data), .burst_end(burst_end), .crc_rx(crc_rx), .err_clr(err_clr),
        .busy(busy[1]), .crc_value(crc_value[1]), .word_cnt(wc1), .done(done[1]),
        .crc_ok(crc_ok[1]), .err_sticky(err_sticky[1])
`ifdef UDMA_CRC_CHK_SYNDROME_EN
       ,.syndrome(syndrome[1])
`endif
    );

    // Reference CRC as polynomial remainder: ((crc ^ bit-reversed word) * x^16) mod G(x).
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
        logic [31:0] r;
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[15-i] = d[i];
        r = {c ^ m, 16'h0000};
        for (int k = 31; k >= 16; k--) if (r[k]) r = r ^ (32'h0001_1021 << (k - 16));
        return r[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: burst phase, words folded in, captured far-end CRC, result flags.
    logic [15:0] seed_m[2] = '{16'h0000, 16'h4ABA};
    int          wmax_m[2] = '{15, 65535};
    int          ph_m[2];
    int          cnt_m[2];
    logic [15:0] crc_m[2], rx_m[2], syn_m[2];
    logic        done_m[2], ok_m[2], err_m[2];

    always @(posedge CLK) begin
        for (int n = 0; n < 2; n++) begin
            if (!RST_n) begin
                ph_m[n] = 0; crc_m[n] = seed_m[n]; cnt_m[n] = 0; rx_m[n] = 0;
                done_m[n] = 0; ok_m[n] = 0; err_m[n] = 0; syn_m[n] = 0;
            end else begin
                logic mismatch;
                mismatch = 1'b0;
                done_m[n] = 1'b0;
                if (ph_m[n] == 2) begin
                    done_m[n] = 1'b1;
                    ok_m[n]   = (crc_m[n] == rx_m[n]);
                    syn_m[n]  = crc_m[n] ^ rx_m[n];
                    mismatch  = !ok_m[n];
                    ph_m[n]   = 0;
                end else if (burst_start) begin
                    ph_m[n] = 1; crc_m[n] = seed_m[n]; cnt_m[n] = 0;
                end else if (ph_m[n] == 1) begin
                    if (data_valid) begin
                        crc_m[n] = crc_ref(crc_m[n], data);
                        cnt_m[n] = (cnt_m[n] < wmax_m[n]) ? cnt_m[n] + 1 : cnt_m[n];
                    end
                    if (burst_end) begin
                        rx_m[n] = crc_rx; ph_m[n] = 2;
                    end
                end
                if (mismatch) err_m[n] = 1'b1;
                else if (err_clr) err_m[n] = 1'b0;
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("busy[%0d]", n), busy[n], ph_m[n] != 0);
            chk($sformatf("crc_value[%0d]", n), crc_value[n], crc_m[n]);
            chk($sformatf("done[%0d]", n), done[n], done_m[n]);
            chk($sformatf("crc_ok[%0d]", n), crc_ok[n], ok_m[n]);
            chk($sformatf("err_sticky[%0d]", n), err_sticky[n], err_m[n]);
`ifdef UDMA_CRC_CHK_SYNDROME_EN
            chk($sformatf("syndrome[%0d]", n), syndrome[n], syn_m[n]);
`endif
        end
        chk("word_cnt[0]", wc0, cnt_m[0]);
        chk("word_cnt[1]", wc1, cnt_m[1]);
    end

    // One clock of stimulus; pulses are dropped just after the edge that samples them.
    task automatic step(input logic bs, input logic dv, input logic [15:0] d,
                        input logic be, input logic [15:0] rx, input logic clr);
        @(negedge CLK);
        burst_start = bs; data_valid = dv; data = d; burst_end = be; crc_rx = rx; err_clr = clr;
        @(posedge CLK);
        #1;
        burst_start = 0; data_valid = 0; burst_end = 0; err_clr = 0;
    endtask

    task automatic wait_done();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST_n = 0; burst_start = 0; data_valid = 0; data = 0; burst_end = 0; crc_rx = 0; err_clr = 0;
        repeat (2) @(negedge CLK);
        RST_n = 1;
        chk("reset crc0", crc_value[0], 16'h0000);
        chk("reset crc1", crc_value[1], 16'h4ABA);
        chk("reset busy1", busy[1], 1'b0);
        chk("reset wc1", wc1, 16'd0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 16'h8000, 0, 0, 0);
        step(0, 0, 0, 1, 16'h1021, 0);
        chk("t1 done not early", done[0], 1'b0);
        wait_done();
        chk("t1 done", done[0], 1'b1);
        chk("t1 crc", crc_value[0], 16'h1021);
        chk("t1 ok", crc_ok[0], 1'b1);
        chk("t1 wc", wc0, 4'd1);
        step(0, 0, 0, 0, 0, 1);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 16'h4000, 0, 0, 0);
        step(0, 0, 0, 1, 16'h1021, 0);
        wait_done();
        chk("t2 crc", crc_value[0], 16'h2042);
        chk("t2 ok", crc_ok[0], 1'b0);
        chk("t2 err", err_sticky[0], 1'b1);
`ifdef UDMA_CRC_CHK_SYNDROME_EN
        chk("t2 syndrome", syndrome[0], 16'h3063);
`endif
        step(0, 0, 0, 0, 0, 1);
        chk("t2 err cleared", err_sticky[0], 1'b0);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 16'h4ABA, 0);
        wait_done();
        chk("t3 done", done[1], 1'b1);
        chk("t3 ok", crc_ok[1], 1'b1);
        chk("t3 wc", wc1, 16'd0);
        step(0, 0, 0, 0, 0, 1);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 16'h8000, 1, 16'h1021, 0);
        wait_done();
        chk("t4 crc", crc_value[0], 16'h1021);
        chk("t4 ok", crc_ok[0], 1'b1);
        chk("t4 wc", wc0, 4'd1);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 16'h1234, 0, 0, 0);
        step(0, 1, 16'hBEEF, 0, 0, 0);
        step(0, 1, 16'h0F0F, 0, 0, 0);
        step(1, 1, 16'hAAAA, 1, 16'h0000, 0);
        step(0, 1, 16'h8000, 0, 0, 0);
        step(0, 0, 0, 1, 16'h1021, 0);
        wait_done();
        chk("t5 ok", crc_ok[0], 1'b1);
        chk("t5 wc", wc0, 4'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 16'hFFFF, 1, 16'h0000, 0);
        chk("t5 idle crc hold", crc_value[0], 16'h1021);
        chk("t5 idle no done", done[0], 1'b0);

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 16'(i * 16'h1357 + 16'h0101), 0, 0, 0);
        step(0, 0, 0, 1, 16'h5A5A, 0);
        wait_done();
        chk("sat wc0", wc0, 4'hF);
        chk("sat wc1", wc1, 16'd20);
        step(0, 0, 0, 0, 0, 1);

        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 16'h1111, 0, 0, 0);
        step(0, 1, 16'h2222, 0, 0, 0);
        @(negedge CLK);
        #3 RST_n = 0;
        #1;
        chk("t6 busy0", busy[0], 1'b0);
        chk("t6 crc0", crc_value[0], 16'h0000);
        chk("t6 crc1", crc_value[1], 16'h4ABA);
        chk("t6 wc0", wc0, 4'd0);
        chk("t6 done", done[0], 1'b0);
        @(negedge CLK);
        RST_n = 1;
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 16'h8000, 0, 0, 0);
        step(0, 0, 0, 1, 16'h1021, 0);
        wait_done();
        chk("t6 after done", done[0], 1'b1);
        chk("t6 after ok", crc_ok[0], 1'b1);

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
